deinterleaver_accum: RTL

//  Write-side counterpart of the activation interleaver used in backprop.

---
 rtl/deinterleaver_accum.sv | 83 ++++++++
 1 files changed

// File: rtl/deinterleaver_accum.sv
// deinterleaver_accum: scatter-accumulates z lanes per cycle into p neuron sums over one junction,
// then drains the sums in natural neuron order, z per beat.
module deinterleaver_accum #(
   parameter int fo    = 2,
   parameter int p     = 32,
   parameter int z     = 8,
   parameter int width = 16,
   localparam int ACC_W = width + $clog2(fo),
   localparam int NC    = fo * p / z,
   localparam int NG    = p / z,
   localparam int CI_W  = NC > 1 ? $clog2(NC) : 1,
   localparam int AI_W  = p > 1 ? $clog2(p) : 1,
   localparam int OI_W  = NG > 1 ? $clog2(NG) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [CI_W-1:0]   cycle_index,
   input  logic [AI_W*z-1:0] memory_index_package,
   input  logic [width*z-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OI_W-1:0]   out_index,
   output logic [ACC_W*z-1:0] data_out,
   output logic              collision_err
);
   typedef enum logic {ACCUM, DRAIN} state_t;
   state_t state_q;
   logic [CI_W-1:0] ci_q;
   logic [OI_W-1:0] oi_q;
   logic err_q, col, in_hs, out_hs;
   logic [AI_W-1:0] addr [z];
   logic signed [ACC_W-1:0] val [z];
   logic signed [ACC_W-1:0] acc_q [p];
   logic signed [ACC_W-1:0] acc_d [p];
   assign in_ready      = state_q == ACCUM;
   assign out_valid     = state_q == DRAIN;
   assign in_hs         = in_valid & in_ready;
   assign out_hs        = out_valid & out_ready;
   assign cycle_index   = ci_q;
   assign out_index     = oi_q;
   assign collision_err = err_q;
   always_comb begin
      for (int k = 0; k < z; k++) begin
         addr[k] = memory_index_package[AI_W*k +: AI_W];
         val[k]  = ACC_W'(signed'(data_in[width*k +: width]));
         data_out[ACC_W*k +: ACC_W] = acc_q[int'(oi_q)*z + k];
      end
   end
   // Each lane reads the old sum, so on a collision the highest lane's write wins.
   always_comb begin
      acc_d = acc_q;
      col   = 1'b0;
      for (int k = 1; k < z; k++)
         for (int j = 0; j < k; j++)
            if (addr[j] == addr[k]) col = 1'b1;
      if (in_hs)
         for (int k = 0; k < z; k++) acc_d[addr[k]] = acc_q[addr[k]] + val[k];
      if (out_hs)
         for (int k = 0; k < z; k++) acc_d[int'(oi_q)*z + k] = '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ACCUM;
         ci_q    <= '0;
         oi_q    <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < p; i++) acc_q[i] <= '0;
      end else begin
         acc_q <= acc_d;
         if (in_hs) begin
            ci_q  <= ci_q == CI_W'(NC - 1) ? '0 : ci_q + 1'b1;
            err_q <= err_q | col;
            if (ci_q == CI_W'(NC - 1)) state_q <= DRAIN;
         end
         if (out_hs) begin
            oi_q <= oi_q == OI_W'(NG - 1) ? '0 : oi_q + 1'b1;
            if (oi_q == OI_W'(NG - 1)) state_q <= ACCUM;
         end
      end
   end
endmodule
